imem_port_arbiter: RTL and testbench
====================================

// Module: imem_port_arbiter
// PURPOSE
//  Controller sharing one single-port, 64-bit-wide instruction RAM between the fetch
//  stage (10-byte instruction-window reads at any byte address) and the program loader
//  (byte writes). Sequences the 2-3 word reads per window, assembles the 80-bit
//  little-endian window, and flags out-of-range addresses. Sits between F-stage and RAM.
// PARAMETERS
//  MEM_BYTES   1024  RAM size in bytes; multiple of 8
//  WORD_AW     7     word-address width, log2(MEM_BYTES/8)
// PORTS
//  clk_i          in   1        clock, all state on rising edge
//  rst_n_i        in   1        reset, synchronous, active-low
//  fetch_req_i    in   1        fetch request; hold until fetch_ack_o
//  fetch_addr_i   in   64       window byte address
//  fetch_ack_o    out  1        one-cycle completion pulse
//  fetch_data_o   out  80       bytes addr..addr+9, byte addr in [7:0]; valid with ack
//  fetch_error_o  out  1        valid with ack: address out of range
//  load_req_i     in   1        loader write request; hold until load_ack_o
//  load_addr_i    in   64       byte address to write
//  load_data_i    in   8        byte to write
//  load_ack_o     out  1        one-cycle completion pulse
//  load_error_o   out  1        valid with ack: address out of range, write dropped
//  mem_en_o       out  1        RAM access this cycle
//  mem_we_o       out  1        1 write, 0 read
//  mem_addr_o     out  WORD_AW  RAM word address
//  mem_wdata_o    out  64       load_data_i replicated x8
//  mem_wstrb_o    out  8        1 << load_addr_i[2:0]
//  mem_rdata_i    in   64       read data, valid cycle after read issue
// BEHAVIOUR
//  - Reset (rst_n_i=0 at edge): state IDLE, every output 0, last_grant=LOAD.
//    Reset mid-operation aborts it: no ack, no further RAM access.
//  - States: IDLE, RD1, RD2, RD3, WR, DONE. Requests sampled only in IDLE.
//    Cycle 0 = IDLE cycle in which the granted request is sampled.
//  - Arbitration in IDLE: one requester -> granted; both -> the one not in
//    last_grant (round-robin), last_grant updated on grant. Never preempts.
//  - Fetch range: error iff fetch_addr_i > MEM_BYTES-10. Error: no RAM access,
//    DONE in cycle 1 with fetch_ack_o=1, fetch_error_o=1, fetch_data_o=0.
//  - Fetch ok: w0=addr[WORD_AW+2:3], off=addr[2:0]; n=2 words if off<=6, else 3.
//    Read word w0+k issued in cycle k+1 (mem_en_o=1, mem_we_o=0); data captured at
//    end of cycle k+2. Window = ({w2,w1,w0} >> 8*off)[79:0]. Ack in cycle n+2
//    (cycle 4 or 5). w0+2 never exceeds last word given the range rule.
//  - Load: error iff load_addr_i >= MEM_BYTES -> no write, ack cycle 1,
//    load_error_o=1. Else cycle 1 (WR): mem_en_o=1, mem_we_o=1, word/strobe/data
//    as above; cycle 2 (DONE): load_ack_o=1.
//  - DONE lasts one cycle -> IDLE. Requester must drop req the cycle after ack;
//    a req still high in IDLE is a new request.
//  - ack/data/error outputs registered; zero outside the ack cycle.
//    mem_* zero except in RDk/WR.
// CONFIGURATION
//  IMEM_LOADER_EN defined: loader port functional as above.
//  Undefined: load_* inputs ignored, load_ack_o=load_error_o=0, mem_we_o=0,
//  mem_wdata_o=mem_wstrb_o=0; fetch always granted; no WR state.
// TESTING
//  RAM model byte i = i[7:0].
//  - fetch addr 0 -> reads words 0,1 in cycles 1,2; ack cycle 4,
//    data 0x09080706050403020100, err 0.
//  - fetch addr 7 -> reads words 0,1,2; ack cycle 5, data 0x100F0E0D0C0B0A090807.
//  - fetch addr 1015 -> ack cycle 1, err 1, data 0, mem_en_o never high;
//    addr 1014 -> ack cycle 4, err 0.
//  - load addr 0x0B data 0xAB -> cycle 1 mem_addr 1, wstrb 0x08,
//    wdata 0xABABABABABABABAB, ack cycle 2; then fetch 8 -> 0x11100F0E0D0CAB0A0908.
//  - both req after reset -> fetch first, then load; both again -> load first;
//    load addr 1024 -> load_error_o=1, no write.
//  - rst_n_i low in cycle 2 of fetch addr 0 -> no ack, all outputs 0 next cycle;
//    without IMEM_LOADER_EN, load_req_i=1 -> load_ack_o stays 0, mem_we_o stays 0.

Source files
------------

// File: rtl/imem_port_arbiter_if.sv
// Fetch / loader / RAM signal bundle for imem_port_arbiter.
// slave = arbiter side, master = fetch stage, loader and RAM side.
interface imem_port_arbiter_if #(
  parameter int WORD_AW = 7
);
  logic                fetch_req_i;
  logic [63:0]         fetch_addr_i;
  logic                fetch_ack_o;
  logic [79:0]         fetch_data_o;
  logic                fetch_error_o;
  logic                load_req_i;
  logic [63:0]         load_addr_i;
  logic [7:0]          load_data_i;
  logic                load_ack_o;
  logic                load_error_o;
  logic                mem_en_o;
  logic                mem_we_o;
  logic [WORD_AW-1:0]  mem_addr_o;
  logic [63:0]         mem_wdata_o;
  logic [7:0]          mem_wstrb_o;
  logic [63:0]         mem_rdata_i;

  modport slave (
    input  fetch_req_i, fetch_addr_i, load_req_i, load_addr_i, load_data_i, mem_rdata_i,
    output fetch_ack_o, fetch_data_o, fetch_error_o, load_ack_o, load_error_o,
           mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o
  );

  modport master (
    output fetch_req_i, fetch_addr_i, load_req_i, load_addr_i, load_data_i, mem_rdata_i,
    input  fetch_ack_o, fetch_data_o, fetch_error_o, load_ack_o, load_error_o,
           mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o
  );
endinterface

// File: rtl/imem_port_arbiter.sv
// Shares one 64-bit single-port instruction RAM between 10-byte fetch windows and
// byte-wide loader writes. Loader port is present only when IMEM_LOADER_EN is defined.
module imem_port_arbiter #(
  parameter int MEM_BYTES = 1024,
  parameter int WORD_AW   = 7
) (
  input logic                clk_i,
  input logic                rst_n_i,
  imem_port_arbiter_if.slave bus
);

`ifdef IMEM_LOADER_EN
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_RD1 = 3'd1, S_RD2 = 3'd2, S_RD3 = 3'd3, S_WR = 3'd4, S_DONE = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_RD1 = 3'd1, S_RD2 = 3'd2, S_RD3 = 3'd3, S_DONE = 3'd5
  } state_t;
`endif

  localparam logic [63:0] FETCH_MAX   = 64'(MEM_BYTES - 10);
  localparam logic [63:0] LOAD_END    = 64'(MEM_BYTES);
  localparam logic        GRANT_FETCH = 1'b0;
  localparam logic        GRANT_LOAD  = 1'b1;

  state_t               r_state;
  logic                 r_last_grant;
  logic [WORD_AW-1:0]   r_w0_addr;
  logic [2:0]           r_off;
  logic                 r_three;
  logic                 r_tail;
  logic [63:0]          r_word0;
  logic [63:0]          r_word1;

  logic                 r_fetch_ack;
  logic [79:0]          r_fetch_data;
  logic                 r_fetch_err;
  logic                 r_load_ack;
  logic                 r_load_err;
  logic                 r_mem_en;
  logic                 r_mem_we;
  logic [WORD_AW-1:0]   r_mem_addr;
  logic [63:0]          r_mem_wdata;
  logic [7:0]           r_mem_wstrb;

  logic                 w_fetch_err;
  logic                 w_load_err;
  logic                 w_grant_load;
  logic [191:0]         w_cat;
  logic [191:0]         w_shifted;
  logic [79:0]          w_window;

  assign w_fetch_err = (bus.fetch_addr_i > FETCH_MAX);
  assign w_load_err  = (bus.load_addr_i >= LOAD_END);

`ifdef IMEM_LOADER_EN
  assign w_grant_load = bus.load_req_i && (!bus.fetch_req_i || (r_last_grant == GRANT_FETCH));
`else
  assign w_grant_load = 1'b0;
`endif

  // Window assembly: the word being returned this cycle is taken straight from the RAM.
  always_comb begin
    w_cat     = 192'd0;
    w_shifted = 192'd0;
    w_window  = 80'd0;
    if (r_tail) begin
      w_cat = {bus.mem_rdata_i, r_word1, r_word0};
    end else begin
      w_cat = {64'd0, bus.mem_rdata_i, r_word0};
    end
    w_shifted = w_cat >> {r_off, 3'b000};
    w_window  = w_shifted[79:0];
  end

  // Control FSM; every output is a register that defaults to zero each cycle.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state      <= S_IDLE;
      r_last_grant <= GRANT_LOAD;
      r_w0_addr    <= '0;
      r_off        <= 3'd0;
      r_three      <= 1'b0;
      r_tail       <= 1'b0;
      r_word0      <= 64'd0;
      r_word1      <= 64'd0;
      r_fetch_ack  <= 1'b0;
      r_fetch_data <= 80'd0;
      r_fetch_err  <= 1'b0;
      r_load_ack   <= 1'b0;
      r_load_err   <= 1'b0;
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= 64'd0;
      r_mem_wstrb  <= 8'd0;
    end else begin
      r_fetch_ack  <= 1'b0;
      r_fetch_data <= 80'd0;
      r_fetch_err  <= 1'b0;
      r_load_ack   <= 1'b0;
      r_load_err   <= 1'b0;
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= 64'd0;
      r_mem_wstrb  <= 8'd0;
      case (r_state)
        S_IDLE: begin
`ifdef IMEM_LOADER_EN
          if (w_grant_load) begin
            r_last_grant <= GRANT_LOAD;
            if (w_load_err) begin
              r_load_ack <= 1'b1;
              r_load_err <= 1'b1;
              r_state    <= S_DONE;
            end else begin
              r_mem_en    <= 1'b1;
              r_mem_we    <= 1'b1;
              r_mem_addr  <= bus.load_addr_i[WORD_AW+2:3];
              r_mem_wdata <= {8{bus.load_data_i}};
              r_mem_wstrb <= 8'd1 << bus.load_addr_i[2:0];
              r_state     <= S_WR;
            end
          end else
`endif
          if (bus.fetch_req_i) begin
            r_last_grant <= GRANT_FETCH;
            if (w_fetch_err) begin
              r_fetch_ack <= 1'b1;
              r_fetch_err <= 1'b1;
              r_state     <= S_DONE;
            end else begin
              r_w0_addr  <= bus.fetch_addr_i[WORD_AW+2:3];
              r_off      <= bus.fetch_addr_i[2:0];
              r_three    <= (bus.fetch_addr_i[2:0] == 3'd7);
              r_tail     <= 1'b0;
              r_mem_en   <= 1'b1;
              r_mem_addr <= bus.fetch_addr_i[WORD_AW+2:3];
              r_state    <= S_RD1;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RD1: begin
          r_mem_en   <= 1'b1;
          r_mem_addr <= r_w0_addr + WORD_AW'(1);
          r_state    <= S_RD2;
        end
        S_RD2: begin
          r_word0 <= bus.mem_rdata_i;
          if (r_three) begin
            r_mem_en   <= 1'b1;
            r_mem_addr <= r_w0_addr + WORD_AW'(2);
          end else begin
            r_mem_en <= 1'b0;
          end
          r_state <= S_RD3;
        end
        // A three-word window spends a second cycle here draining the last read.
        S_RD3: begin
          if (r_three && !r_tail) begin
            r_word1 <= bus.mem_rdata_i;
            r_tail  <= 1'b1;
            r_state <= S_RD3;
          end else begin
            r_fetch_ack  <= 1'b1;
            r_fetch_data <= w_window;
            r_tail       <= 1'b0;
            r_state      <= S_DONE;
          end
        end
`ifdef IMEM_LOADER_EN
        S_WR: begin
          r_load_ack <= 1'b1;
          r_state    <= S_DONE;
        end
`endif
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.fetch_ack_o   = r_fetch_ack;
  assign bus.fetch_data_o  = r_fetch_data;
  assign bus.fetch_error_o = r_fetch_err;
  assign bus.load_ack_o    = r_load_ack;
  assign bus.load_error_o  = r_load_err;
  assign bus.mem_en_o      = r_mem_en;
  assign bus.mem_we_o      = r_mem_we;
  assign bus.mem_addr_o    = r_mem_addr;
  assign bus.mem_wdata_o   = r_mem_wdata;
  assign bus.mem_wstrb_o   = r_mem_wstrb;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Randomized bench for imem_port_arbiter against a byte-array reference model.
// Loader scenarios are exercised when IMEM_LOADER_EN is defined.
module tb_imem_port_arbiter;
  localparam int MEM_BYTES = 1024;
  localparam int WORD_AW   = 7;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  imem_port_arbiter_if #(.WORD_AW(WORD_AW)) bus();

  imem_port_arbiter #(.MEM_BYTES(MEM_BYTES), .WORD_AW(WORD_AW)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] ram     [0:MEM_BYTES-1];
  logic [7:0] ref_mem [0:MEM_BYTES-1];
  logic       ram_clear = 1'b1;
  logic       last_load;

  // RAM model: registered read, byte-strobed write
  always @(posedge clk) begin
    if (ram_clear) begin
      for (int i = 0; i < MEM_BYTES; i++) ram[i] <= i[7:0];
    end else if (bus.mem_en_o) begin
      for (int b = 0; b < 8; b++) begin
        if (bus.mem_we_o) begin
          if (bus.mem_wstrb_o[b]) ram[{bus.mem_addr_o, b[2:0]}] <= bus.mem_wdata_o[8*b +: 8];
        end else begin
          bus.mem_rdata_i[8*b +: 8] <= ram[{bus.mem_addr_o, b[2:0]}];
        end
      end
    end
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [79:0] ref_window(input logic [63:0] a);
    logic [79:0] w;
    w = 80'd0;
    for (int i = 0; i < 10; i++) w[8*i +: 8] = ref_mem[int'(a[9:0]) + i];
    return w;
  endfunction

  task automatic run_fetch(input logic [63:0] addr);
    logic        err;
    int          n;
    int          exp_cyc;
    int          w0;
    logic [79:0] exp_data;
    bit          done;
    done     = 1'b0;
    err      = (addr > 64'(MEM_BYTES - 10));
    n        = (addr[2:0] == 3'd7) ? 3 : 2;
    exp_cyc  = err ? 1 : n + 2;
    exp_data = err ? 80'd0 : ref_window(addr);
    w0       = int'(addr[9:3]);
    bus.fetch_req_i  = 1'b1;
    bus.fetch_addr_i = addr;
    for (int c = 1; c <= 8 && !done; c++) begin
      @(posedge clk); #1;
      if (!err && c <= n)
        check("fetch_rd", {bus.mem_en_o, bus.mem_we_o, bus.mem_addr_o}, {1'b1, 1'b0, 7'(w0 + c - 1)});
      else
        check("fetch_mem_quiet", {bus.mem_en_o, bus.mem_we_o, bus.mem_addr_o}, 128'd0);
      if (bus.fetch_ack_o) begin
        check("fetch_ack_cycle", c, exp_cyc);
        check("fetch_data", bus.fetch_data_o, exp_data);
        check("fetch_err", bus.fetch_error_o, err);
        bus.fetch_req_i = 1'b0;
        last_load = 1'b0;
        done = 1'b1;
      end else begin
        check("fetch_data_idle", {bus.fetch_error_o, bus.fetch_data_o}, 128'd0);
      end
    end
    if (!done) begin
      check("fetch_timeout", 1'b0, 1'b1);
      bus.fetch_req_i = 1'b0;
    end
    @(posedge clk); #1;
  endtask

`ifdef IMEM_LOADER_EN
  task automatic run_load(input logic [63:0] addr, input logic [7:0] data);
    logic       err;
    logic [7:0] strb;
    bit         done;
    done = 1'b0;
    err  = (addr >= 64'(MEM_BYTES));
    strb = 8'h01 << addr[2:0];
    bus.load_req_i  = 1'b1;
    bus.load_addr_i = addr;
    bus.load_data_i = data;
    for (int c = 1; c <= 8 && !done; c++) begin
      @(posedge clk); #1;
      if (!err && c == 1) begin
        check("load_wr", {bus.mem_en_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_wstrb_o},
              {1'b1, 1'b1, 7'(addr[9:3]), strb});
        check("load_wdata", bus.mem_wdata_o, {8{data}});
      end else begin
        check("load_mem_quiet", {bus.mem_en_o, bus.mem_we_o, bus.mem_wstrb_o}, 128'd0);
      end
      if (bus.load_ack_o) begin
        check("load_ack_cycle", c, err ? 1 : 2);
        check("load_err", bus.load_error_o, err);
        if (!err) ref_mem[int'(addr[9:0])] = data;
        bus.load_req_i = 1'b0;
        last_load = 1'b1;
        done = 1'b1;
      end
    end
    if (!done) begin
      check("load_timeout", 1'b0, 1'b1);
      bus.load_req_i = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  task automatic run_both(input logic [63:0] faddr, input logic [63:0] laddr, input logic [7:0] ldata);
    logic exp_fetch_first;
    logic fetch_first;
    bit   f_done;
    bit   l_done;
    bit   first_seen;
    logic lerr;
    f_done = 1'b0; l_done = 1'b0; first_seen = 1'b0; fetch_first = 1'b0;
    exp_fetch_first = last_load;
    lerr = (laddr >= 64'(MEM_BYTES));
    bus.fetch_req_i = 1'b1; bus.fetch_addr_i = faddr;
    bus.load_req_i  = 1'b1; bus.load_addr_i  = laddr; bus.load_data_i = ldata;
    for (int c = 1; c <= 30 && !(f_done && l_done); c++) begin
      @(posedge clk); #1;
      if (bus.fetch_ack_o) begin
        if (!first_seen) fetch_first = 1'b1;
        first_seen = 1'b1;
        check("both_fetch_err", bus.fetch_error_o, faddr > 64'(MEM_BYTES - 10));
        if (faddr <= 64'(MEM_BYTES - 10)) check("both_fetch_data", bus.fetch_data_o, ref_window(faddr));
        bus.fetch_req_i = 1'b0;
        f_done = 1'b1;
      end
      if (bus.load_ack_o) begin
        first_seen = 1'b1;
        check("both_load_err", bus.load_error_o, lerr);
        if (!lerr) ref_mem[int'(laddr[9:0])] = ldata;
        bus.load_req_i = 1'b0;
        l_done = 1'b1;
      end
    end
    check("both_done", {f_done, l_done}, 2'b11);
    check("both_order_fetch_first", fetch_first, exp_fetch_first);
    last_load = fetch_first;
    bus.fetch_req_i = 1'b0;
    bus.load_req_i  = 1'b0;
    @(posedge clk); #1;
  endtask
`else
  task automatic run_ignored_load(input logic [63:0] faddr);
    bus.load_req_i  = 1'b1;
    bus.load_addr_i = 64'($urandom_range(0, MEM_BYTES - 1));
    bus.load_data_i = 8'($urandom);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      check("noload_quiet", {bus.load_ack_o, bus.load_error_o, bus.mem_en_o, bus.mem_we_o}, 128'd0);
    end
    run_fetch(faddr);
    check("noload_we", {bus.load_ack_o, bus.mem_we_o, bus.mem_wstrb_o, bus.mem_wdata_o}, 128'd0);
    bus.load_req_i = 1'b0;
  endtask
`endif

  task automatic check_all_zero(input string tag);
    check(tag, {bus.fetch_ack_o, bus.fetch_error_o, bus.load_ack_o, bus.load_error_o,
                bus.mem_en_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_wstrb_o, bus.fetch_data_o}, 128'd0);
    check({tag, "_wdata"}, bus.mem_wdata_o, 64'd0);
  endtask

  function automatic logic [63:0] rand_fetch_addr();
    if ($urandom_range(0, 7) == 0) return 64'(MEM_BYTES - 9 + $urandom_range(0, 40));
    return 64'($urandom_range(0, MEM_BYTES - 10));
  endfunction

  initial begin
    bus.fetch_req_i  = 1'b0; bus.fetch_addr_i = 64'd0;
    bus.load_req_i   = 1'b0; bus.load_addr_i  = 64'd0; bus.load_data_i = 8'd0;
    for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = i[7:0];
    last_load = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset_state");
    ram_clear = 1'b0;
    rst_n     = 1'b1;

    run_fetch(64'd0);
    run_fetch(64'd7);
    run_fetch(64'd1015);
    run_fetch(64'd1014);
    run_fetch(64'hFFFF_FFFF_FFFF_FFF8);

    // Reset during the second read cycle of a fetch
    bus.fetch_req_i = 1'b1; bus.fetch_addr_i = 64'd0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0; bus.fetch_req_i = 1'b0;
    @(posedge clk); #1;
    check_all_zero("rst_abort");
    rst_n = 1'b1;
    last_load = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check("rst_abort_quiet", {bus.fetch_ack_o, bus.mem_en_o}, 128'd0);
    end

`ifdef IMEM_LOADER_EN
    run_both(64'd16, 64'd20, 8'h5A);
    run_both(64'd40, 64'd3, 8'hC3);
    run_load(64'h0B, 8'hAB);
    run_fetch(64'd8);
    run_load(64'd1024, 8'hCC);
    run_fetch(64'd1016);
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 3))
        0, 1:    run_fetch(rand_fetch_addr());
        2:       run_load(64'($urandom_range(0, MEM_BYTES + 8)), 8'($urandom));
        default: run_both(rand_fetch_addr(), 64'($urandom_range(0, MEM_BYTES + 8)), 8'($urandom));
      endcase
    end
`else
    run_ignored_load(64'd8);
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 3) == 0) run_ignored_load(rand_fetch_addr());
      else run_fetch(rand_fetch_addr());
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
